// File: rtl/uart_tx_if.sv
// UART transmitter bus: configuration, TX FIFO read port and serial line.
interface uart_tx_if #(
  parameter int unsigned DIV_WIDTH = 16
);

  logic                 i_riscv_uart_en;
  logic [DIV_WIDTH-1:0] i_riscv_uart_baud_div;
  logic                 i_riscv_uart_par_en;
  logic                 i_riscv_uart_par_odd;
  logic                 i_riscv_uart_stop2;
  logic                 i_riscv_uart_fifo_empty;
  logic [7:0]           i_riscv_uart_fifo_rdata;
  logic                 o_riscv_uart_fifo_rinc;
  logic                 o_riscv_uart_tx;
  logic                 o_riscv_uart_busy;

  // Side that configures the transmitter and owns the FIFO.
  modport master (
    output i_riscv_uart_en,
    output i_riscv_uart_baud_div,
    output i_riscv_uart_par_en,
    output i_riscv_uart_par_odd,
    output i_riscv_uart_stop2,
    output i_riscv_uart_fifo_empty,
    output i_riscv_uart_fifo_rdata,
    input  o_riscv_uart_fifo_rinc,
    input  o_riscv_uart_tx,
    input  o_riscv_uart_busy
  );

  // Transmitter side.
  modport slave (
    input  i_riscv_uart_en,
    input  i_riscv_uart_baud_div,
    input  i_riscv_uart_par_en,
    input  i_riscv_uart_par_odd,
    input  i_riscv_uart_stop2,
    input  i_riscv_uart_fifo_empty,
    input  i_riscv_uart_fifo_rdata,
    output o_riscv_uart_fifo_rinc,
    output o_riscv_uart_tx,
    output o_riscv_uart_busy
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a TX FIFO and serialises them as
// start / 8 data (LSB first) / optional parity / 1 or 2 stop bits.
// Frame settings are captured when the byte is popped and held for the frame.
module uart_tx #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic     i_riscv_uart_clk,
  input  logic     i_riscv_uart_rst_n,
  uart_tx_if.slave bus
);

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned IDX_WIDTH = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state_q;
  logic                   tx_q;
  logic                   busy_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [IDX_WIDTH-1:0]   bit_idx_q;
  logic                   stop_idx_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic                   stop2_q;

  logic                   rinc_c;
  logic                   period_end_c;
  logic [DIV_WIDTH-1:0]   div_eff_c;

  // A zero divisor behaves as one clock per bit.
  assign div_eff_c = (bus.i_riscv_uart_baud_div == '0) ? DIV_WIDTH'(1)
                                                        : bus.i_riscv_uart_baud_div;

  // Pop strobe: only while idle, enabled, data available and out of reset.
  assign rinc_c = i_riscv_uart_rst_n && (state_q == IDLE) &&
                  bus.i_riscv_uart_en && !bus.i_riscv_uart_fifo_empty;

  // Last clock of the current bit period.
  assign period_end_c = (cnt_q == DIV_WIDTH'(div_q - DIV_WIDTH'(1)));

  assign bus.o_riscv_uart_fifo_rinc = rinc_c;
  assign bus.o_riscv_uart_tx        = tx_q;
  assign bus.o_riscv_uart_busy      = busy_q;

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge i_riscv_uart_clk or negedge i_riscv_uart_rst_n) begin
    if (!i_riscv_uart_rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (rinc_c) begin
            shreg_q    <= bus.i_riscv_uart_fifo_rdata;
            div_q      <= div_eff_c;
            par_en_q   <= bus.i_riscv_uart_par_en;
            par_bit_q  <= (^bus.i_riscv_uart_fifo_rdata) ^ bus.i_riscv_uart_par_odd;
            stop2_q    <= bus.i_riscv_uart_stop2;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end

        START: begin
          if (period_end_c) begin
            cnt_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= DIV_WIDTH'(cnt_q + DIV_WIDTH'(1));
          end
        end

        DATA: begin
          if (period_end_c) begin
            cnt_q   <= '0;
            shreg_q <= shreg_q >> 1;
            if (bit_idx_q == IDX_WIDTH'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= PARITY;
              end else begin
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= STOP;
              end
            end else begin
              bit_idx_q <= IDX_WIDTH'(bit_idx_q + IDX_WIDTH'(1));
              tx_q      <= shreg_q[1];
            end
          end else begin
            cnt_q <= DIV_WIDTH'(cnt_q + DIV_WIDTH'(1));
          end
        end

        PARITY: begin
          if (period_end_c) begin
            cnt_q      <= '0;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= STOP;
          end else begin
            cnt_q <= DIV_WIDTH'(cnt_q + DIV_WIDTH'(1));
          end
        end

        STOP: begin
          tx_q <= 1'b1;
          if (period_end_c) begin
            cnt_q <= '0;
            if (!stop2_q || stop_idx_q) begin
              stop_idx_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end else begin
            cnt_q <= DIV_WIDTH'(cnt_q + DIV_WIDTH'(1));
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model feeds bytes, every pop pushes the expected
// per-clock line levels into a scoreboard that is drained clock by clock.
module tb_uart_tx;

  localparam int unsigned DIV_WIDTH = 16;

  logic clk;
  logic rst_n;

  uart_tx_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

  uart_tx #(.DIV_WIDTH(DIV_WIDTH)) dut (
    .i_riscv_uart_clk   (clk),
    .i_riscv_uart_rst_n (rst_n),
    .bus                (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rinc_cnt = 0;

  byte unsigned fifo_q[$];
  bit           exp_q[$];
  bit           exp_bit;
  bit           exp_rinc;
  byte unsigned popped;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected line level for every clock of one frame.
  task automatic push_frame(input byte unsigned b, input logic [DIV_WIDTH-1:0] div,
                            input bit pe, input bit po, input bit s2);
    int d;
    bit bits[$];
    d = (div == 0) ? 1 : int'(div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pe) bits.push_back((^b) ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < d; k++) exp_q.push_back(bits[i]);
  endtask

  // FIFO model outputs, updated just after each rising edge.
  initial begin
    bus.i_riscv_uart_fifo_empty = 1'b1;
    bus.i_riscv_uart_fifo_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.i_riscv_uart_fifo_empty = (fifo_q.size() == 0);
      bus.i_riscv_uart_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Per-clock monitor on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_tx", bus.o_riscv_uart_tx, 1);
      check("rst_busy", bus.o_riscv_uart_busy, 0);
      check("rst_rinc", bus.o_riscv_uart_fifo_rinc, 0);
    end else if (exp_q.size() != 0) begin
      exp_bit = exp_q.pop_front();
      check("frame_tx", bus.o_riscv_uart_tx, exp_bit);
      check("frame_busy", bus.o_riscv_uart_busy, 1);
      check("frame_rinc", bus.o_riscv_uart_fifo_rinc, 0);
    end else begin
      exp_rinc = bus.i_riscv_uart_en && !bus.i_riscv_uart_fifo_empty;
      check("idle_tx", bus.o_riscv_uart_tx, 1);
      check("idle_busy", bus.o_riscv_uart_busy, 0);
      check("idle_rinc", bus.o_riscv_uart_fifo_rinc, exp_rinc);
      if (exp_rinc && fifo_q.size() != 0) begin
        popped = fifo_q.pop_front();
        push_frame(popped, bus.i_riscv_uart_baud_div, bus.i_riscv_uart_par_en,
                   bus.i_riscv_uart_par_odd, bus.i_riscv_uart_stop2);
        rinc_cnt++;
      end
    end
  end

  task automatic set_cfg(input int div, input bit pe, input bit po, input bit s2);
    @(posedge clk);
    #2;
    bus.i_riscv_uart_baud_div = DIV_WIDTH'(div);
    bus.i_riscv_uart_par_en   = pe;
    bus.i_riscv_uart_par_odd  = po;
    bus.i_riscv_uart_stop2    = s2;
  endtask

  task automatic wait_rinc(input int budget);
    int start;
    bit got;
    start = rinc_cnt;
    got   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (rinc_cnt > start) begin
        got = 1'b1;
        break;
      end
    end
    check("rinc_wait", got, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !bus.o_riscv_uart_busy) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_wait", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_riscv_uart_en       = 1'b1;
    bus.i_riscv_uart_baud_div = DIV_WIDTH'(4);
    bus.i_riscv_uart_par_en   = 1'b0;
    bus.i_riscv_uart_par_odd  = 1'b0;
    bus.i_riscv_uart_stop2    = 1'b0;
    fifo_q.push_back(8'h3C);
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", bus.o_riscv_uart_tx, 1);
    check("reset_busy", bus.o_riscv_uart_busy, 0);
    check("reset_rinc", bus.o_riscv_uart_fifo_rinc, 0);
    rst_n = 1'b1;
    wait_idle(200);

    // 0x55 at div 4, 8N1
    set_cfg(4, 0, 0, 0);
    rinc_cnt = 0;
    fifo_q.push_back(8'h55);
    wait_idle(200);
    check("cnt_55", rinc_cnt, 1);

    // 0x07 at div 3, even then odd parity
    set_cfg(3, 1, 0, 0);
    fifo_q.push_back(8'h07);
    wait_idle(200);
    set_cfg(3, 1, 1, 0);
    fifo_q.push_back(8'h07);
    wait_idle(200);

    // three back-to-back bytes, div 2, two stop bits
    set_cfg(2, 0, 0, 1);
    rinc_cnt = 0;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h80);
    fifo_q.push_back(8'hE7);
    wait_idle(300);
    check("cnt_three", rinc_cnt, 3);

    // empty FIFO, then data with transmit disabled
    set_cfg(4, 0, 0, 0);
    rinc_cnt = 0;
    repeat (40) @(negedge clk);
    check("cnt_empty", rinc_cnt, 0);
    bus.i_riscv_uart_en = 1'b0;
    fifo_q.push_back(8'h81);
    repeat (40) @(negedge clk);
    check("cnt_dis", rinc_cnt, 0);
    check("fifo_dis", fifo_q.size(), 1);
    bus.i_riscv_uart_en = 1'b1;
    wait_idle(200);
    check("cnt_en", rinc_cnt, 1);

    // enable dropped mid-frame: frame completes, next byte waits
    rinc_cnt = 0;
    fifo_q.push_back(8'h12);
    fifo_q.push_back(8'h34);
    wait_rinc(50);
    @(posedge clk);
    #2;
    bus.i_riscv_uart_en = 1'b0;
    repeat (120) @(negedge clk);
    check("hold_fifo", fifo_q.size(), 1);
    check("hold_cnt", rinc_cnt, 1);
    check("hold_busy", bus.o_riscv_uart_busy, 0);
    bus.i_riscv_uart_en = 1'b1;
    wait_idle(200);

    // settings changed mid-frame must not affect it
    set_cfg(5, 0, 0, 0);
    fifo_q.push_back(8'hC3);
    wait_rinc(50);
    set_cfg(2, 1, 1, 1);
    wait_idle(200);

    // reset in the middle of the data bits
    set_cfg(4, 1, 0, 0);
    rinc_cnt = 0;
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h0F);
    wait_rinc(50);
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst_busy", bus.o_riscv_uart_busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_tx", bus.o_riscv_uart_tx, 1);
    check("async_busy", bus.o_riscv_uart_busy, 0);
    check("async_rinc", bus.o_riscv_uart_fifo_rinc, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_idle(200);
    check("cnt_rst", rinc_cnt, 2);

    // zero divisor behaves as one
    set_cfg(0, 0, 0, 0);
    fifo_q.push_back(8'hA5);
    wait_idle(100);

    // random bytes and settings, settings scrambled mid-frame
    for (int i = 0; i < 6; i++) begin
      set_cfg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      fifo_q.push_back(8'($urandom_range(0, 255)));
      wait_rinc(50);
      set_cfg(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle(200);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
